// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants for the round datapath blocks: state,
//               byte and byte-count sizes, plus the control FSM encoding
//               used by the iterative substitution engines.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  localparam int c_STATE_W = 2;

  localparam logic [c_STATE_W-1:0] c_IDLE = 2'd0;
  localparam logic [c_STATE_W-1:0] c_RUN  = 2'd1;
  localparam logic [c_STATE_W-1:0] c_DONE = 2'd2;

  // True for lane counts that divide the 16-byte state into whole groups
  // of power-of-two size.
  function automatic bit legal_lane_count(input int n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : inv_sbox
// Description : Combinational AES inverse S-box (FIPS-197 InvSubBytes
//               table), one byte in, one byte out.
// Ports       : i_byte - input byte
//               o_byte - inverse S-box value of i_byte
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5;
      8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
      8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e;
      8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
      8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82;
      8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
      8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44;
      8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
      8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32;
      8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
      8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b;
      8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
      8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66;
      8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
      8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49;
      8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
      8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64;
      8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
      8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc;
      8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
      8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50;
      8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
      8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57;
      8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
      8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00;
      8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
      8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05;
      8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
      8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f;
      8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
      8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03;
      8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
      8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41;
      8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
      8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce;
      8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22;
      8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
      8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8;
      8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
      8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71;
      8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
      8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e;
      8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
      8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b;
      8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
      8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe;
      8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
      8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33;
      8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
      8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59;
      8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
      8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9;
      8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
      8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f;
      8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
      8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d;
      8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
      8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c;
      8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
      8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e;
      8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
      8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63;
      8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
      default: o_byte = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : inv_sub_bytes_seq
// Description : Iterative AES InvSubBytes engine. Accepts a 128-bit state,
//               substitutes BYTES_PER_CYCLE bytes per clock in place through
//               a bank of inverse S-boxes, then holds the result until the
//               downstream consumer takes it.
// Ports       : i_Clk   - clock, rising edge
//               i_Rst   - asynchronous active-high reset
//               i_Valid - upstream state present on i_Data
//               o_Ready - engine idle, can accept a state
//               i_Data  - input state, byte 0 at [127:120]
//               o_Valid - o_Data holds a finished result
//               i_Ready - downstream accepts o_Data
//               o_Data  - substituted state, same byte order as i_Data
//               o_Busy  - engine is substituting or holding a result
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  input  logic [AES_STATE_W-1:0] i_Data,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic [AES_STATE_W-1:0] o_Data,
  output logic                   o_Busy
);

  // Number of RUN cycles and width of the group counter.
  localparam int c_n     = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_grp_w = AES_BYTE_W * BYTES_PER_CYCLE;

  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  generate
    if (!legal_lane_count(BYTES_PER_CYCLE)) begin : g_bad_param
      $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic [c_STATE_W-1:0]   r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [AES_STATE_W-1:0] r_data;

  // The state is viewed as c_n groups of BYTES_PER_CYCLE bytes; group 0
  // holds the lowest-numbered bytes (most significant bits).
  logic [c_grp_w-1:0]     w_groups [c_n];
  logic [c_grp_w-1:0]     w_sel;
  logic [c_grp_w-1:0]     w_sub;
  logic [AES_STATE_W-1:0] w_data_next;

  genvar gi;
  generate
    for (gi = 0; gi < c_n; gi++) begin : g_grp
      assign w_groups[gi] = r_data[AES_STATE_W-1-gi*c_grp_w -: c_grp_w];
      // Only the group addressed by the counter is rewritten; the rest
      // pass through unchanged.
      assign w_data_next[AES_STATE_W-1-gi*c_grp_w -: c_grp_w] =
        (r_cnt == c_cnt_w'(gi)) ? w_sub : w_groups[gi];
    end

    if (c_n == 1) begin : g_sel_one
      assign w_sel = w_groups[0];
    end else begin : g_sel_mux
      assign w_sel = w_groups[r_cnt];
    end

    for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
      inv_sbox u_inv_sbox (
        .i_byte (w_sel[c_grp_w-1-gi*AES_BYTE_W -: AES_BYTE_W]),
        .o_byte (w_sub[c_grp_w-1-gi*AES_BYTE_W -: AES_BYTE_W])
      );
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_Valid) begin
            r_data  <= i_Data;
            r_cnt   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_data <= w_data_next;
          if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_DONE: begin
          if (i_Ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register so they react
  // to the asynchronous reset without waiting for an edge.
  assign o_Ready = (r_state == c_IDLE);
  assign o_Valid = (r_state == c_DONE);
  assign o_Busy  = (r_state == c_RUN) || (r_state == c_DONE);
  assign o_Data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_sub_bytes_seq
// Description : Self-checking bench for inv_sub_bytes_seq. One instance per
//               legal lane count shares the same stimulus; expected values
//               come from a forward S-box built from GF(2^8) arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_seq;

  localparam int c_ninst = 5;   // instance k uses 1<<k lanes

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid_in;
  logic         ready_in;
  logic [127:0] data_in;
  logic         o_ready [c_ninst];
  logic         o_valid [c_ninst];
  logic         o_busy  [c_ninst];
  logic [127:0] o_data  [c_ninst];

  genvar gi;
  generate
    for (gi = 0; gi < c_ninst; gi++) begin : g_dut
      inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << gi)) u_dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Valid (valid_in),
        .o_Ready (o_ready[gi]),
        .i_Data  (data_in),
        .o_Valid (o_valid[gi]),
        .i_Ready (ready_in),
        .o_Data  (o_data[gi]),
        .o_Busy  (o_busy[gi])
      );
    end
  endgenerate

  logic [7:0] ub_in;
  logic [7:0] ub_out;
  inv_sbox u_unit (.i_byte(ub_in), .o_byte(ub_out));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [7:0] fwd [256];
  logic [7:0] inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1b;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_model();
    logic [7:0] x_inv, s;
    for (int x = 0; x < 256; x++) begin
      x_inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) x_inv = 8'(y);
      s = x_inv ^ rotl8(x_inv, 1) ^ rotl8(x_inv, 2) ^ rotl8(x_inv, 3) ^ rotl8(x_inv, 4) ^ 8'h63;
      fwd[x] = s;
      inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] map_state(input logic [127:0] d, input bit use_inv);
    logic [127:0] res, tmp;
    logic [7:0]   b;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      tmp = d >> (8 * (15 - k));
      b   = tmp[7:0];
      res = {res[119:0], (use_inv ? inv[b] : fwd[b])};
    end
    return res;
  endfunction

  // ---------------- checkers ----------------
  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < c_ninst; i++) begin
      check1($sformatf("%s valid[%0d]", tag, i), o_valid[i], 1'b0);
      check1($sformatf("%s ready[%0d]", tag, i), o_ready[i], 1'b1);
      check1($sformatf("%s busy[%0d]", tag, i), o_busy[i], 1'b0);
      check128($sformatf("%s data[%0d]", tag, i), o_data[i], 128'h0);
    end
  endtask

  task automatic wait_idle();
    bit all_rdy;
    all_rdy = 1'b0;
    for (int c = 0; c < 50 && !all_rdy; c++) begin
      @(negedge clk);
      all_rdy = 1'b1;
      for (int i = 0; i < c_ninst; i++) if (!o_ready[i]) all_rdy = 1'b0;
    end
    if (!all_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: ready not seen on all instances, want 1 within 50 cycles");
    end
  endtask

  // One transaction with i_Ready held high: checks latency, data and
  // a single-cycle o_Valid pulse on every instance.
  task automatic run_vec(input logic [127:0] din, input logic [127:0] exp, input string name);
    int         lat  [c_ninst];
    int         vcnt [c_ninst];
    logic [127:0] dat [c_ninst];
    wait_idle();
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = din;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < c_ninst; i++) begin
      lat[i] = 0; vcnt[i] = 0; dat[i] = '0;
      check1($sformatf("%s accept ready[%0d]", name, i), o_ready[i], 1'b0);
      check1($sformatf("%s accept busy[%0d]", name, i), o_busy[i], 1'b1);
    end
    @(negedge clk);
    valid_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < c_ninst; i++) begin
        if (o_valid[i]) begin
          if (lat[i] == 0) begin
            lat[i] = k;
            dat[i] = o_data[i];
          end
          vcnt[i]++;
        end
      end
    end
    for (int i = 0; i < c_ninst; i++) begin
      check_int($sformatf("%s latency[%0d]", name, i), lat[i], 16 >> i);
      check128($sformatf("%s data[%0d]", name, i), dat[i], exp);
      check_int($sformatf("%s valid_cycles[%0d]", name, i), vcnt[i], 1);
    end
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p, bp_exp;
    bit           seen [c_ninst];

    vecs[0] = '{128'h63cab7040953d051cd60e0e7ba70e18c, 128'h00102030405060708090a0b0c0d0e0f0, "known"};
    vecs[1] = '{{16{8'h63}}, {16{8'h00}}, "all63"};
    vecs[2] = '{{16{8'h00}}, {16{8'h52}}, "all00"};
    vecs[3] = '{{16{8'h16}}, {16{8'hff}}, "all16"};
    vecs[4] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 128'h00112233445566778899aabbccddeeff, "fips"};

    build_model();

    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = '0;
    ub_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Standalone table: inverse must undo the forward S-box.
    for (int x = 0; x < 256; x++) begin
      ub_in = fwd[x];
      #1;
      check_int($sformatf("unit inv_sbox(%02h)", fwd[x]), int'(ub_out), x);
    end

    for (int v = 0; v < 5; v++) run_vec(vecs[v].din, vecs[v].exp, vecs[v].name);

    // Backpressure: result held with i_Ready low, new i_Valid ignored.
    bp_exp = vecs[4].exp;
    wait_idle();
    @(negedge clk);
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = vecs[4].din;
    @(negedge clk);
    data_in  = vecs[0].din;
    repeat (20) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < c_ninst; i++) begin
        check1($sformatf("bp valid[%0d] c%0d", i, c), o_valid[i], 1'b1);
        check1($sformatf("bp ready[%0d] c%0d", i, c), o_ready[i], 1'b0);
        check128($sformatf("bp data[%0d] c%0d", i, c), o_data[i], bp_exp);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < c_ninst; i++) begin
      check1($sformatf("bp release valid[%0d]", i), o_valid[i], 1'b0);
      check1($sformatf("bp release ready[%0d]", i), o_ready[i], 1'b1);
      check1($sformatf("bp release busy[%0d]", i), o_busy[i], 1'b0);
      check128($sformatf("bp release data[%0d]", i), o_data[i], bp_exp);
    end

    // Reset after two RUN edges, asserted between clock edges.
    wait_idle();
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = vecs[4].din;
    for (int i = 0; i < c_ninst; i++) seen[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < c_ninst; i++) if (o_valid[i]) seen[i] = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrun_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      check1($sformatf("midrun no valid pulse[%0d]", i), seen[i], 1'b0);
    run_vec(vecs[0].din, vecs[0].exp, "after_rst");

    // Random round trip: substituting sbox(p) must give back p.
    for (int r = 0; r < 1000; r++) begin
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_vec(map_state(p, 1'b0), p, $sformatf("rand%0d", r));
    end

    // Also confirm the model-predicted inverse on one random state.
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_vec(p, map_state(p, 1'b1), "rand_inv");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
